// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: freezes, branch flushes, load-use stalls, halt drain.
// Optional perf counters enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_mem_wait,
  input  logic             i_ex_branch_taken,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rd,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_id_halt,
  input  logic             i_resume,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_stage_en,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam int unsigned DW = 3;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    DRAIN   = 2'b01,
    HALTED  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_drain, w_drain_next;
  logic          r_halted;
  logic          w_lu;

  assign w_lu = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                 (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

  // Control decode from registered state and live hazard inputs.
  always_comb begin
    o_pc_en      = 1'b0;
    o_ifid_en    = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_stage_en   = 1'b0;
    w_next       = r_state;
    w_drain_next = r_drain;
    case (r_state)
      RUN: begin
        if (i_mem_wait) begin
          o_pc_en = 1'b0;
        end else if (i_ex_branch_taken) begin
          o_pc_en      = 1'b1;
          o_ifid_en    = 1'b1;
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
          o_stage_en   = 1'b1;
        end else if (w_lu) begin
          o_idex_flush = 1'b1;
          o_stage_en   = 1'b1;
        end else if (i_id_halt) begin
          o_ifid_en    = 1'b1;
          o_ifid_flush = 1'b1;
          o_stage_en   = 1'b1;
          w_next       = DRAIN;
          w_drain_next = DW'(DRAIN_CYCLES);
        end else begin
          o_pc_en    = 1'b1;
          o_ifid_en  = 1'b1;
          o_stage_en = 1'b1;
        end
      end
      DRAIN: begin
        o_ifid_en    = 1'b1;
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
        o_stage_en   = !i_mem_wait;
        if (!i_mem_wait) begin
          if (r_drain <= DW'(1)) w_next = HALTED;
          else                   w_drain_next = r_drain - DW'(1);
        end
      end
      HALTED: begin
        if (i_resume) w_next = RUN;
      end
      default: w_next = RUN;
    endcase
    if (rst) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      o_stage_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_drain  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_drain  <= w_drain_next;
      r_halted <= (w_next == HALTED);
    end
  end

  assign o_halted = r_halted;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic             w_stall_ev, w_flush_ev;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  assign w_stall_ev = (r_state == RUN) && !i_mem_wait && !i_ex_branch_taken && w_lu;
  assign w_flush_ev = (r_state == RUN) && !i_mem_wait && i_ex_branch_taken;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_ev && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_ev && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_count = r_stall_cnt;
  assign o_flush_count = r_flush_cnt;
`else
  assign o_stall_count = '0;
  assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors, negedge monitor.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mem_wait = 1'b0, br = 1'b0, mem_read = 1'b0;
  logic [4:0]       ex_rd = '0, rs1 = '0, rs2 = '0;
  logic             u1 = 1'b0, u2 = 1'b0, halt = 1'b0, resume = 1'b0;
  logic             pc_en, ifid_en, ifid_flush, idex_flush, stage_en, halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  typedef struct {
    int               id;
    logic [5:0]       ctl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .i_mem_wait(mem_wait), .i_ex_branch_taken(br), .i_ex_mem_read(mem_read),
    .i_ex_rd(ex_rd), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_uses_rs1(u1), .i_id_uses_rs2(u2), .i_id_halt(halt), .i_resume(resume),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
    .o_idex_flush(idex_flush), .o_stage_en(stage_en), .o_halted(halted),
    .o_stall_count(stall_count), .o_flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_flush, stage_en, halted}
  task automatic step(input logic r, input logic mw, input logic b, input logic mr,
                      input logic [4:0] rd, input logic [4:0] s1, input logic us1,
                      input logic [4:0] s2, input logic us2, input logic h, input logic res,
                      input logic [5:0] ctl, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_wait = mw; br = b; mem_read = mr; ex_rd = rd;
    rs1 = s1; u1 = us1; rs2 = s2; u2 = us2; halt = h; resume = res;
    e.id  = n_step;
    e.ctl = ctl;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    e.sc = CNT_W'(sc);
    e.fc = CNT_W'(fc);
`else
    e.sc = CNT_W'(0 * sc);
    e.fc = CNT_W'(0 * fc);
`endif
    sb.push_back(e);
    n_step++;
  endtask

  // Monitor: pop one expectation per cycle and compare away from the edge.
  initial begin
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_en, ifid_en, ifid_flush, idex_flush, stage_en, halted};
        n_assert++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl step%0d: got %b expected %b", e.id, act, e.ctl);
        end
        n_assert++;
        if (stall_count !== e.sc || flush_count !== e.fc) begin
          n_fail++;
          $display("FAIL counters step%0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.id, stall_count, flush_count, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    //    rst mw br mr rd    s1    u1 s2    u2 h  res ctl        sc fc
    step(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b001100, 0, 0); // in reset
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b110010, 0, 0); // idle run
    step(0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 6'b000110, 0, 0); // LU rs1
    step(0, 0, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 0, 0, 6'b110010, 1, 0); // load moved on
    step(0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0, 6'b000110, 1, 0); // LU rs2
    step(0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 6'b111110, 2, 0); // branch beats LU
    step(0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 6'b110010, 2, 1); // x0 no hazard
    step(0, 0, 0, 1, 5'd5, 5'd5, 0, 5'd0, 0, 0, 0, 6'b110010, 2, 1); // rs1 unused
    step(0, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 6'b000000, 2, 1); // mem_wait freeze
    step(0, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 6'b000000, 2, 1);
    step(0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 6'b111110, 2, 1); // flush after wait
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b110010, 2, 2);
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b011010, 2, 2); // halt accepted
    step(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 6'b011110, 2, 2); // drain, br/resume ignored
    step(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b011100, 2, 2); // drain waiting
    step(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b011100, 2, 2);
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b011110, 2, 2);
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b011110, 2, 2);
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000001, 2, 2); // halted, 5 edges on
    step(0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 6'b000001, 2, 2); // inputs ignored
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 6'b000001, 2, 2); // resume pulse
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b110010, 2, 2); // back in run
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b011010, 2, 2); // second halt
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b011110, 2, 2);
    step(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b001100, 0, 0); // reset mid-drain
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b110010, 0, 0); // run, not halted
    step(0, 0, 0, 1, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 6'b000110, 0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b110010, 1, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain_scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
